// File: rtl/sram_pkg.sv
// Shared definitions for the 32-bit-over-16-bit SRAM word controller:
// FSM state encoding, latched operation type, SRAM data width and the
// default address offset / per-half wait length.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    localparam int          SRAM_DW         = 16;
    localparam int unsigned DEF_ADDR_OFFSET = 1024;
    localparam int unsigned DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/sram_wait_timer.sv
// Per-half wait counter. Counts 0..WAIT_CYCLES-1 while enabled and wraps to
// 0 on terminal count; clr_i forces it back to 0.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr_i     hold counter at 0
//   en_i      advance counter
//   tc_o      counter is on its last cycle (cnt == WAIT_CYCLES-1)
module sram_wait_timer #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sram_word_controller.sv
// Serves 32-bit read/write requests on a 16-bit asynchronous SRAM as two
// halves: low half at the even location (LO), high half at the odd (HI).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   addr, wdata       byte address (word aligned) and write data, latched on accept
//   r_en, w_en        request strobes; w_en wins when both are set
//   rdata             registered read data
//   ready             idle-and-free, or one-cycle completion pulse in DONE
//   SRAM_*            SRAM pins, strobes active low
module sram_word_controller
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_OFFSET = DEF_ADDR_OFFSET,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    input  logic               r_en,
    input  logic               w_en,
    output logic [31:0]        rdata,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);
    state_e      state_q, state_d;
    op_e         op_q;
    logic [31:0] addr_q, wdata_q, rdata_q, phys;
    logic        req, busy, tc, accept, dq_oe;
    logic [SRAM_DW-1:0] dq_out;
    logic        unused_phys;

    assign req    = r_en | w_en;
    assign busy   = (state_q == LO) || (state_q == HI);
    assign accept = (state_q == IDLE) && req;

    sram_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr_i(~busy),
        .en_i (busy),
        .tc_o (tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = LO;
            LO:      if (tc)  state_d = HI;
            HI:      if (tc)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            op_q    <= w_en ? OP_WRITE : OP_READ;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Each half is captured on its last wait cycle, when the SRAM output has settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (op_q == OP_READ && tc) begin
            if (state_q == LO)      rdata_q[15:0]  <= SRAM_DQ;
            else if (state_q == HI) rdata_q[31:16] <= SRAM_DQ;
        end
    end

    // 32-bit wrapping subtraction; only the halfword-index bits reach the pins.
    assign phys        = addr_q - ADDR_OFFSET;
    assign unused_phys = ^{phys[31:SRAM_AW+1], phys[1:0]};
    assign SRAM_ADDR   = {phys[SRAM_AW:2], (state_q == HI)};

    assign SRAM_CE_N = ~busy;
    assign SRAM_UB_N = ~busy;
    assign SRAM_LB_N = ~busy;
    assign SRAM_OE_N = ~(busy && op_q == OP_READ);
    // WE_N rises on the last wait cycle so address and data are held past the write edge.
    assign SRAM_WE_N = ~(busy && op_q == OP_WRITE && !tc);

    assign dq_oe   = busy && (op_q == OP_WRITE);
    assign dq_out  = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DW{1'bz}};

    assign rdata = rdata_q;
    assign ready = (state_q == IDLE) ? ~req : (state_q == DONE);

endmodule

// File: tb/tb_sram_word_controller.sv
module tb_sram_word_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic        r_en = 1'b0, w_en = 1'b0;
    logic [31:0] rdata;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

    int n_chk = 0;
    int n_pass = 0;

    sram_word_controller dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .r_en(r_en), .w_en(w_en),
        .rdata(rdata), .ready(ready), .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_CE_N(SRAM_CE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    always #5 clk = ~clk;

    // Behavioural 256Kx16 SRAM: writes on the clock while CE/WE are low,
    // drives the bus while CE/OE are low and WE is high.
    logic [15:0] mem [0:262143];
    always @(posedge clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;
    end
    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 16'hzzzz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Issues one request as a single-cycle pulse and records cycles 1..6 after acceptance.
    logic [6:1]  we_v, oe_v, rdy_v, ce_v;
    logic [17:0] a1, a3;
    logic [31:0] rd5;
    task automatic run_req(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        w_en = we; r_en = re; addr = a; wdata = d;
        @(posedge clk);
        #1;
        w_en = 1'b0; r_en = 1'b0; addr = 32'h500;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            we_v[c]  = SRAM_WE_N;
            oe_v[c]  = SRAM_OE_N;
            rdy_v[c] = ready;
            ce_v[c]  = SRAM_CE_N;
            if (c == 1) a1 = SRAM_ADDR;
            if (c == 3) a3 = SRAM_ADDR;
            if (c == 5) rd5 = rdata;
        end
    endtask

    int first_rdy, second_rdy;
    logic rdy6;
    logic [17:0] a7;
    logic [31:0] rd_second, rd_before;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        chk("rst_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
        chk("rst_ce_ub_lb", {29'd0, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 32'd7);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;

        run_req(1'b1, 1'b0, 32'h400, 32'hDEADBEEF);
        chk("wr_we_n", {26'd0, we_v}, {26'd0, 6'b111010});
        chk("wr_ready", {27'd0, rdy_v[5:1]}, {27'd0, 5'b10000});
        chk("wr_oe_n", {28'd0, oe_v[4:1]}, {28'd0, 4'b1111});
        chk("wr_addr_lo", {14'd0, a1}, 32'd0);
        chk("wr_addr_hi", {14'd0, a3}, 32'd1);
        chk("wr_mem0", {16'd0, mem[0]}, 32'h0000BEEF);
        chk("wr_mem1", {16'd0, mem[1]}, 32'h0000DEAD);

        run_req(1'b0, 1'b1, 32'h400, 32'h0);
        chk("rd_data", rd5, 32'hDEADBEEF);
        chk("rd_ready", {27'd0, rdy_v[5:1]}, {27'd0, 5'b10000});
        chk("rd_oe_n", {27'd0, oe_v[5:1]}, {27'd0, 5'b10000});
        chk("rd_we_n", {27'd0, we_v[5:1]}, {27'd0, 5'b11111});
        chk("rd_ce_n", {27'd0, ce_v[5:1]}, {27'd0, 5'b10000});

        run_req(1'b1, 1'b0, 32'h404, 32'h33332222);
        run_req(1'b1, 1'b0, 32'h40C, 32'h5A5AA5A5);
        run_req(1'b0, 1'b1, 32'h40C, 32'h0);
        chk("pulse_addr_lo", {14'd0, a1}, 32'd6);
        chk("pulse_addr_hi", {14'd0, a3}, 32'd7);
        chk("pulse_rdata", rd5, 32'h5A5AA5A5);

        // r_en held across two back-to-back requests
        first_rdy = 0; second_rdy = 0; rdy6 = 1'b1; a7 = '1; rd_second = '0;
        @(negedge clk);
        r_en = 1'b1; addr = 32'h400;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 6) rdy6 = ready;
            if (c == 7) a7 = SRAM_ADDR;
            if (ready && first_rdy == 0) begin
                first_rdy = c;
                addr = 32'h404;
            end else if (ready && second_rdy == 0) begin
                second_rdy = c;
                rd_second = rdata;
                r_en = 1'b0;
            end
        end
        r_en = 1'b0;
        chk("held_first_ready", first_rdy, 32'd5);
        chk("held_idle_not_ready", {31'd0, rdy6}, 32'd0);
        chk("held_second_addr", {14'd0, a7}, 32'd2);
        chk("held_second_ready", second_rdy, 32'd11);
        chk("held_second_rdata", rd_second, 32'h33332222);

        rd_before = rdata;
        run_req(1'b1, 1'b1, 32'h408, 32'h12345678);
        chk("both_mem4", {16'd0, mem[4]}, 32'h00005678);
        chk("both_mem5", {16'd0, mem[5]}, 32'h00001234);
        chk("both_rdata_kept", rdata, 32'h33332222);
        chk("both_oe_n", {28'd0, oe_v[4:1]}, {28'd0, 4'b1111});

        run_req(1'b1, 1'b0, 32'h410, 32'h11112222);

        // Reset during the HI half of a write
        @(negedge clk);
        w_en = 1'b1; addr = 32'h410; wdata = 32'hAAAA5555;
        @(posedge clk);
        #1;
        w_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_we_low", {31'd0, SRAM_WE_N}, 32'd0);
        chk("mid_addr_hi", {14'd0, SRAM_ADDR}, 32'd9);
        rst = 1'b1;
        #1;
        chk("mid_rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        chk("mid_rst_ce_n", {31'd0, SRAM_CE_N}, 32'd1);
        chk("mid_rst_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
        chk("mid_rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, ready}, 32'd1);
        chk("post_rst_mem8", {16'd0, mem[8]}, 32'h00005555);
        chk("post_rst_mem9", {16'd0, mem[9]}, 32'h00001111);

        run_req(1'b0, 1'b1, 32'h400, 32'h0);
        chk("post_rst_read", rd5, 32'hDEADBEEF);
        chk("post_rst_rd_ready", {27'd0, rdy_v[5:1]}, {27'd0, 5'b10000});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
